waveform_loader: RTL and testbench

WAVEFORM_LOADER -- requirements
Module: waveform_loader

---
 rtl/waveform_loader.sv | 139 +++++++++++++
 tb/tb_waveform_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_loader.sv
// Frame receiver for the waveform RAM: sync byte, 512 x 24-bit samples sent MSB first,
// then an 8-bit additive checksum. An idle gap inside a frame aborts it.
//
// state | meaning
// IDLE  | hunting for SYNC_BYTE, other bytes dropped
// DATA  | assembling 3-byte samples, one RAM write per sample
// CHECK | waiting for the checksum byte
// DONE  | one-cycle result pulse, input stalled
module waveform_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid_in,
    output logic        byte_ready_out,
    output logic [8:0]  wr_addr_out,
    output logic [23:0] wr_data_out,
    output logic        wr_en_out,
    output logic        busy_out,
    output logic        load_done_out,
    output logic        load_ok_out
);

    typedef enum logic [1:0] {IDLE, DATA, CHECK, DONE} state_t;

    state_t      state, nextState;
    logic        accept;
    logic        timerExpired;
    logic [1:0]  phase;
    logic [7:0]  byte0, byte1;
    logic [7:0]  checksum;
    logic [8:0]  sampleIndex;
    logic [23:0] timer;

    assign byte_ready_out = (state != DONE);
    assign busy_out       = (state != IDLE);
    assign load_done_out  = (state == DONE);
    assign accept         = byte_valid_in && byte_ready_out;
    // Down-counter reloaded on every accepted byte; zero means the gap limit is reached.
    assign timerExpired   = (timer == 24'd0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept && byte_in == SYNC_BYTE) nextState = DATA;
            end
            DATA: begin
                if (accept) begin
                    if (phase == 2'd2 && sampleIndex == 9'd511) nextState = CHECK;
                end else if (timerExpired) begin
                    nextState = DONE;
                end
            end
            CHECK: begin
                if (accept || timerExpired) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            phase       <= 2'd0;
            byte0       <= 8'd0;
            byte1       <= 8'd0;
            checksum    <= 8'd0;
            sampleIndex <= 9'd0;
            timer       <= 24'd0;
            wr_en_out   <= 1'b0;
            wr_addr_out <= 9'd0;
            wr_data_out <= 24'd0;
            load_ok_out <= 1'b0;
        end else begin
            wr_en_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && byte_in == SYNC_BYTE) begin
                        phase       <= 2'd0;
                        checksum    <= 8'd0;
                        sampleIndex <= 9'd0;
                        timer       <= TIMEOUT_CYCLES - 24'd1;
                        load_ok_out <= 1'b0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        timer    <= TIMEOUT_CYCLES - 24'd1;
                        checksum <= checksum + byte_in;
                        case (phase)
                            2'd0: begin
                                byte0 <= byte_in;
                                phase <= 2'd1;
                            end
                            2'd1: begin
                                byte1 <= byte_in;
                                phase <= 2'd2;
                            end
                            default: begin
                                wr_en_out   <= 1'b1;
                                wr_addr_out <= sampleIndex;
                                wr_data_out <= {byte0, byte1, byte_in};
                                sampleIndex <= sampleIndex + 9'd1;
                                phase       <= 2'd0;
                            end
                        endcase
                    end else if (timerExpired) begin
                        load_ok_out <= 1'b0;
                    end else begin
                        timer <= timer - 24'd1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        load_ok_out <= (byte_in == checksum);
                    end else if (timerExpired) begin
                        load_ok_out <= 1'b0;
                    end else begin
                        timer <= timer - 24'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_loader.sv
// Randomised bench for waveform_loader: a frame-level model predicts every RAM write,
// the checksum result and the timeout point.
module tb_waveform_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic [8:0]  wr_addr_out;
    logic [23:0] wr_data_out;
    logic        wr_en_out;
    logic        busy_out;
    logic        load_done_out;
    logic        load_ok_out;

    waveform_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(24'd100)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .byte_in(byte_in),
        .byte_valid_in(byte_valid_in),
        .byte_ready_out(byte_ready_out),
        .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out),
        .wr_en_out(wr_en_out),
        .busy_out(busy_out),
        .load_done_out(load_done_out),
        .load_ok_out(load_ok_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [8:0]  addr;
        logic [23:0] data;
    } wr_t;

    wr_t        expQ[$];
    logic [7:0] frameBytes[1536];
    int         nChecks = 0;
    int         nPass = 0;
    int         doneCount = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else nPass++;
    endtask

    always @(negedge clk_in) begin
        if (load_done_out) doneCount++;
        if (wr_en_out) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", 32'(wr_addr_out), 32'h1000);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("wr_addr", 32'(wr_addr_out), 32'(e.addr));
                check("wr_data", 32'(wr_data_out), 32'(e.data));
            end
        end
    end

    function automatic void buildFrame(input bit randomData);
        for (int n = 0; n < 1536; n++)
            frameBytes[n] = randomData ? 8'($urandom) : 8'(n % 256);
    endfunction

    function automatic logic [7:0] frameSum();
        int s = 0;
        for (int n = 0; n < 1536; n++) s += frameBytes[n];
        return 8'(s % 256);
    endfunction

    function automatic void queueWrites(input int nSamples);
        wr_t e;
        for (int k = 0; k < nSamples; k++) begin
            e.addr = 9'(k);
            e.data = {frameBytes[3*k], frameBytes[3*k+1], frameBytes[3*k+2]};
            expQ.push_back(e);
        end
    endfunction

    // Returns just after the clock edge that accepted the byte.
    task automatic sendByte(input logic [7:0] b, input bit throttle);
        int tries = 0;
        bit taken = 0;
        while (!taken && tries < 64) begin
            @(negedge clk_in);
            byte_in = b;
            byte_valid_in = !throttle || tries >= 6 || ($urandom_range(0, 2) != 0);
            taken = byte_valid_in && byte_ready_out;
            tries++;
            @(posedge clk_in);
        end
        if (!taken) check("byte_accept", 32'd0, 32'd1);
    endtask

    task automatic sendData(input int nBytes, input bit throttle);
        for (int n = 0; n < nBytes; n++) begin
            sendByte(frameBytes[n], throttle);
            if (n % 3 == 2) begin
                #1;
                check("wr_strobe", 32'(wr_en_out), 32'd1);
            end
        end
    endtask

    task automatic runFrame(input logic [7:0] cks, input bit expOk, input bit throttle,
                            input bit offerDone);
        int doneBefore;
        doneBefore = doneCount;
        queueWrites(512);
        sendByte(SYNC, throttle);
        #1;
        check("busy_after_sync", 32'(busy_out), 32'd1);
        check("ok_cleared", 32'(load_ok_out), 32'd0);
        sendData(1536, throttle);
        sendByte(cks, throttle);
        #1;
        check("done_pulse", 32'(load_done_out), 32'd1);
        check("ready_in_done", 32'(byte_ready_out), 32'd0);
        check("load_ok", 32'(load_ok_out), 32'(expOk));
        byte_in = SYNC;
        byte_valid_in = offerDone;
        @(posedge clk_in);
        #1;
        byte_valid_in = 1'b0;
        check("done_byte_ignored", 32'(busy_out), 32'd0);
        check("done_single", 32'(load_done_out), 32'd0);
        check("ok_held", 32'(load_ok_out), 32'(expOk));
        check("write_count", 32'(expQ.size()), 32'd0);
        check("done_count", 32'(doneCount), 32'(doneBefore + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t[5];
        int doneBefore;

        rst_in = 1'b1;
        byte_in = 8'd0;
        byte_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("rst_ready", 32'(byte_ready_out), 32'd1);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_wr_en", 32'(wr_en_out), 32'd0);
        check("rst_done", 32'(load_done_out), 32'd0);
        check("rst_ok", 32'(load_ok_out), 32'd0);
        check("rst_addr", 32'(wr_addr_out), 32'd0);
        check("rst_data", 32'(wr_data_out), 32'd0);

        buildFrame(0);
        runFrame(8'h00, 1'b1, 1'b0, 1'b0);
        runFrame(8'h01, 1'b0, 1'b0, 1'b0);

        sendByte(8'h00, 1'b0);
        sendByte(8'hFF, 1'b0);
        sendByte(8'h12, 1'b0);
        #1;
        check("noise_idle", 32'(busy_out), 32'd0);
        buildFrame(1);
        runFrame(frameSum(), 1'b1, 1'b0, 1'b0);

        // Timeout: one byte lands exactly on the expiry cycle and must win.
        for (int i = 0; i < 5; i++) t[i] = 8'($urandom);
        frameBytes[0] = t[0];
        frameBytes[1] = t[1];
        frameBytes[2] = t[2];
        queueWrites(1);
        doneBefore = doneCount;
        sendByte(SYNC, 1'b0);
        sendByte(t[0], 1'b0);
        sendByte(t[1], 1'b0);
        #1;
        byte_valid_in = 1'b0;
        repeat (99) @(posedge clk_in);
        sendByte(t[2], 1'b0);
        #1;
        check("edge_accept_write", 32'(wr_en_out), 32'd1);
        check("edge_accept_busy", 32'(busy_out), 32'd1);
        sendByte(t[3], 1'b0);
        sendByte(t[4], 1'b0);
        #1;
        byte_valid_in = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk_in);
            #1;
            if (k == 99) check("timeout_early", 32'(load_done_out), 32'd0);
            if (k == 100) begin
                check("timeout_done", 32'(load_done_out), 32'd1);
                check("timeout_ok", 32'(load_ok_out), 32'd0);
            end
        end
        @(posedge clk_in);
        #1;
        check("timeout_idle", 32'(busy_out), 32'd0);
        check("timeout_writes", 32'(expQ.size()), 32'd0);
        check("timeout_done_count", 32'(doneCount), 32'(doneBefore + 1));

        buildFrame(0);
        runFrame(8'h00, 1'b1, 1'b1, 1'b1);

        queueWrites(233);
        sendByte(SYNC, 1'b0);
        sendData(700, 1'b0);
        #1;
        doneBefore = doneCount;
        rst_in = 1'b1;
        byte_valid_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        check("midrst_busy", 32'(busy_out), 32'd0);
        check("midrst_wr_en", 32'(wr_en_out), 32'd0);
        check("midrst_addr", 32'(wr_addr_out), 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        check("midrst_no_done", 32'(doneCount), 32'(doneBefore));
        check("midrst_writes", 32'(expQ.size()), 32'd0);
        runFrame(8'h00, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
